// File: rtl/mips_if_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch FIFO.
package mips_if_pkg;

   // Fetch request state: idle, waiting on a live request, or draining a squashed one
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] PC_STEP   = 32'd4;
   localparam int          ENTRY_W   = 64;

   // One prefetched word together with the address of the following instruction
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc_plus4;
   } fifo_entry_t;

   // Redirect targets are always word addresses; low bits are discarded
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// Small ring-buffer FIFO holding prefetched {instr, pc+4} entries.
// DEPTH must be a power of two so the pointers wrap naturally.
module if_prefetch_fifo
   import mips_if_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_push,
   input  logic                    i_pop,
   input  logic                    i_clear,
   input  logic [ENTRY_W-1:0]      i_data,
   output logic [ENTRY_W-1:0]      o_head,
   output logic [$clog2(DEPTH):0]  o_count
);

   localparam int               PTR_W  = $clog2(DEPTH);
   localparam logic [PTR_W:0]   FULL_C = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   ZERO_C = (PTR_W+1)'(0);
   localparam logic [PTR_W-1:0] ONE_P  = PTR_W'(1);
   localparam logic [PTR_W:0]   ONE_C  = (PTR_W+1)'(1);

   logic [ENTRY_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [PTR_W:0]     r_count;
   logic               w_do_push;
   logic               w_do_pop;

   assign w_do_push = i_push & (r_count != FULL_C);
   assign w_do_pop  = i_pop  & (r_count != ZERO_C);
   assign o_head    = r_mem[r_rd_ptr];
   assign o_count   = r_count;

   // Storage array: written on push only, contents irrelevant while empty
   always_ff @(posedge clk) begin
      if (w_do_push && !i_clear) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers and occupancy; clear wins over push and pop
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_count  <= ZERO_C;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + ONE_P;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + ONE_P;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + ONE_C;
            2'b01:   r_count <= r_count - ONE_C;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one request at a time to a
// multi-cycle instruction memory and buffers returned words in a prefetch FIFO.
// Optional build macro IF_PERF_CNT_EN adds fetch and bubble performance counters.
module if_fetch_unit
   import mips_if_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        load_forward_stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction_out,
   output logic [31:0] pc_out,
   output logic        valid_out
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_bubble_cnt
`endif
);

   localparam int               CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] ZERO_C  = CNT_W'(0);

   fetch_state_t      r_state;
   logic [31:0]       r_fetch_pc;
   logic              r_req;
   logic [31:0]       r_addr;

   logic              w_advance;
   logic              w_valid;
   logic              w_pop;
   logic              w_push;
   logic [CNT_W-1:0]  w_count;
   logic [CNT_W-1:0]  w_count_after;
   logic [ENTRY_W-1:0] w_fifo_head;
   fifo_entry_t       w_head;
   fifo_entry_t       w_push_entry;

   assign w_advance     = ~stall & ~load_forward_stall;
   assign w_valid       = (w_count != ZERO_C);
   assign w_pop         = w_advance & w_valid & ~branch_taken;
   assign w_push        = (r_state == WAIT) & imem_ack & ~branch_taken;
   // Issue decisions look at occupancy after this cycle's pop
   assign w_count_after = w_count - {{(CNT_W-1){1'b0}}, w_pop};
   assign w_head        = fifo_entry_t'(w_fifo_head);
   assign w_push_entry  = '{instr: imem_rdata, pc_plus4: r_fetch_pc + PC_STEP};

   assign imem_req  = r_req;
   assign imem_addr = r_addr;
   assign valid_out = w_valid;

   if_prefetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_clear (branch_taken),
      .i_data  (w_push_entry),
      .o_head  (w_fifo_head),
      .o_count (w_count)
   );

   // Present the FIFO head to IF/ID, or an all-zero bubble when nothing is buffered
   always_comb begin
      instruction_out = NOP_INSTR;
      pc_out          = 32'h0000_0000;
      if (w_valid) begin
         instruction_out = w_head.instr;
         pc_out          = w_head.pc_plus4;
      end else begin
         instruction_out = NOP_INSTR;
         pc_out          = 32'h0000_0000;
      end
   end

   // Fetch FSM with registered request outputs and fetch PC; redirect takes priority
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_fetch_pc <= RESET_PC;
         r_req      <= 1'b0;
         r_addr     <= 32'h0000_0000;
      end else begin
         if (branch_taken) begin
            r_fetch_pc <= align_word(branch_target);
         end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + PC_STEP;
         end else begin
            r_fetch_pc <= r_fetch_pc;
         end

         case (r_state)
            IDLE: begin
               if (!branch_taken && (w_count_after < DEPTH_C)) begin
                  r_state <= WAIT;
                  r_req   <= 1'b1;
                  r_addr  <= r_fetch_pc;
               end else begin
                  r_state <= IDLE;
                  r_req   <= 1'b0;
               end
            end
            WAIT: begin
               if (imem_ack) begin
                  // Data is pushed or, under a redirect, dropped; either way go idle
                  r_state <= IDLE;
                  r_req   <= 1'b0;
               end else if (branch_taken) begin
                  r_state <= DISCARD;
                  r_req   <= 1'b1;
               end else begin
                  r_state <= WAIT;
                  r_req   <= 1'b1;
               end
            end
            DISCARD: begin
               if (imem_ack) begin
                  r_state <= IDLE;
                  r_req   <= 1'b0;
               end else begin
                  r_state <= DISCARD;
                  r_req   <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

`ifdef IF_PERF_CNT_EN
   logic [31:0] r_perf_fetch_cnt;
   logic [31:0] r_perf_bubble_cnt;

   assign perf_fetch_cnt  = r_perf_fetch_cnt;
   assign perf_bubble_cnt = r_perf_bubble_cnt;

   // Count delivered words and cycles where IF/ID wanted an instruction but got a bubble
   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_fetch_cnt  <= 32'h0000_0000;
         r_perf_bubble_cnt <= 32'h0000_0000;
      end else begin
         if (w_push) begin
            r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
         end
         if (w_advance && !w_valid && !branch_taken) begin
            r_perf_bubble_cnt <= r_perf_bubble_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
